program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time upstream stage of the CPU datapath that fills program memory through the unused BRAM port B.
- Receives a byte stream over a valid/ready handshake and assembles 16-bit instruction words, high byte first.
- Writes each word to BRAM port B at incrementing addresses starting at 0.
- Holds the datapath in reset through `cpu_reset` until a load completes, then releases it so the PC starts fetching at address 0.

Parameters:
- ADDR_WIDTH, 10, BRAM port B address width; DEPTH = 2**ADDR_WIDTH words.
- DATA_WIDTH, 16, instruction word width written to port B. Upper bits beyond 16 are zero-filled if DATA_WIDTH > 16.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load.
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data holds a valid byte.
- rx_ready  output  1  loader accepts a byte this cycle.
- addr_b  output  ADDR_WIDTH  BRAM port B address.
- data_b  output  DATA_WIDTH  BRAM port B write data.
- we_b  output  1  BRAM port B write enable.
- cpu_reset  output  1  reset to datapath/PC/IR; high while not DONE.
- busy  output  1  load in progress.
- done  output  1  program loaded and CPU released.
- error  output  1  rejected length header.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Asserting reset forces state IDLE immediately.
- Reset values: rx_ready=0, addr_b=0, data_b=0, we_b=0, cpu_reset=1, busy=0, done=0, error=0. Internal word count and length are 0.
- Byte transfer: a byte transfers only on a cycle where rx_valid=1 and rx_ready=1. Otherwise rx_data is ignored and the byte is not consumed.
- rx_ready is 1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO. All outputs are registered.
- Stream format: a 16-bit length L is sent as two bytes, MSB first. It is followed by L words, each sent as two bytes, MSB first.
- Valid lengths: 1 ≤ L ≤ DEPTH.

State machine:
- IDLE: waits for start.
  - start=1 → LEN_HI; busy=1; internal count cleared to 0.
- LEN_HI: on transfer, latch L[15:8] → LEN_LO.
- LEN_LO: on transfer, latch L[7:0] and check L.
  - L==0 or L>DEPTH → ERROR.
  - Otherwise → DATA_HI.
- DATA_HI: on transfer, latch word[15:8] → DATA_LO.
- DATA_LO: on transfer, latch word[7:0] → WRITE.
- WRITE: exactly one cycle with we_b=1, addr_b=count, data_b=assembled word.
  - Then count increments.
  - count+1==L → DONE; otherwise → DATA_HI.
- DONE: busy=0, done=1, cpu_reset=0. Holds until start.
  - start → LEN_HI; cpu_reset=1 and done=0 on the next cycle.
- ERROR: busy=0, error=1, cpu_reset=1, rx_ready=0. Holds until start.
  - start → LEN_HI; error clears on the next cycle.

Timing:
- Last data byte accepted in cycle N: we_b=1 in cycle N+1, done=1 and cpu_reset=0 in cycle N+2.
- Minimum 3 cycles per word: two byte transfers plus the WRITE cycle.

Boundaries:
- start while busy (LEN_*/DATA_*/WRITE) is ignored.
- start and a byte transfer in the same IDLE cycle: the byte is not consumed, because rx_ready=0 in IDLE.
- L==DEPTH: the last write is at addr DEPTH-1. There is no wrap and no write to address 0 again.
- addr_b holds its last value when we_b=0, and we_b is never high outside WRITE.
- Reset mid-load: immediate return to IDLE. No further writes. The partial program is left in BRAM. The next load restarts at address 0.
- Count width: count is ADDR_WIDTH+1 bits so that L==DEPTH compares correctly.

Test Plan:
1. Reset state: assert reset asynchronously mid-cycle → all outputs at reset values immediately; cpu_reset=1, we_b=0.
2. Three-word load: start, then stream 00 03 12 34 AB CD 00 FF with rx_valid held high → exactly three we_b pulses: (addr 0, 0x1234), (addr 1, 0xABCD), (addr 2, 0x00FF). done=1 and cpu_reset=0 two cycles after the last byte.
3. Backpressure: stream 00 02 DE AD BE EF with rx_valid toggled randomly; also present a byte during WRITE → no byte is lost or duplicated; writes are (0, 0xDEAD) and (1, 0xBEEF).
4. Bad length: header 00 00 → error=1, no we_b. Then start with header 04 01 (1025 > 1024) → error=1, no we_b. Then start with a valid header 00 01 → load completes and error clears.
5. Boundary length: header 04 00 followed by 1024 words → last write at addr 0x3FF, 1024 total writes, no write to addr 0 after the first.
6. Reset mid-load and start while busy: pulse start while in DATA_LO → ignored. Assert reset after the third data byte → IDLE, no pending write. A new load of 00 01 55 AA writes (0, 0x55AA).

Source files
------------

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Boot loader that takes a length-prefixed byte stream, writes
//            16-bit words to BRAM port B and holds the CPU in reset until done.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic                  we_b,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int          CNT_W = ADDR_WIDTH + 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN_HI  = 3'd1;
    localparam logic [2:0] ST_LEN_LO  = 3'd2;
    localparam logic [2:0] ST_DATA_HI = 3'd3;
    localparam logic [2:0] ST_DATA_LO = 3'd4;
    localparam logic [2:0] ST_WRITE   = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;
    localparam logic [2:0] ST_ERROR   = 3'd7;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            hi_q, hi_d;

    logic                  rx_ready_d;
    logic [ADDR_WIDTH-1:0] addr_b_d;
    logic [DATA_WIDTH-1:0] data_b_d;
    logic                  we_b_d;
    logic                  cpu_reset_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  error_d;

    logic                  xfer;
    logic [15:0]           len_rx;
    logic                  len_bad;
    logic [CNT_W-1:0]      count_inc;
    logic                  last_word;
    logic [15:0]           word_w;
    logic [DATA_WIDTH-1:0] word_ext;

    assign xfer      = rx_valid & rx_ready;
    assign len_rx    = {len_q[15:8], rx_data};
    assign len_bad   = (len_rx == 16'd0) || ({16'd0, len_rx} > DEPTH);
    // count is one bit wider than the address so a full-depth load compares cleanly
    assign count_inc = count_q + 1'b1;
    assign last_word = (32'(count_inc) == {16'd0, len_q});
    assign word_w    = {hi_q, rx_data};

    generate
        if (DATA_WIDTH > 16) begin : g_wide
            assign word_ext = {{(DATA_WIDTH-16){1'b0}}, word_w};
        end else begin : g_narrow
            assign word_ext = word_w[DATA_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            len_q     <= '0;
            hi_q      <= '0;
            rx_ready  <= 1'b0;
            addr_b    <= '0;
            data_b    <= '0;
            we_b      <= 1'b0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            len_q     <= len_d;
            hi_q      <= hi_d;
            rx_ready  <= rx_ready_d;
            addr_b    <= addr_b_d;
            data_b    <= data_b_d;
            we_b      <= we_b_d;
            cpu_reset <= cpu_reset_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        len_d   = len_q;
        hi_d    = hi_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    count_d = '0;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d   = len_rx;
                    state_d = len_bad ? ST_ERROR : ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (xfer) begin
                    hi_d    = rx_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (xfer) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                count_d = count_inc;
                state_d = last_word ? ST_DONE : ST_DATA_HI;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        rx_ready_d  = (state_d == ST_LEN_HI)  || (state_d == ST_LEN_LO) ||
                      (state_d == ST_DATA_HI) || (state_d == ST_DATA_LO);
        we_b_d      = (state_d == ST_WRITE);
        busy_d      = rx_ready_d || we_b_d;
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERROR);
        cpu_reset_d = (state_d != ST_DONE);
        addr_b_d    = addr_b;
        data_b_d    = data_b;
        if (we_b_d) begin
            addr_b_d = count_q[ADDR_WIDTH-1:0];
            data_b_d = word_ext;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Directed self-checking bench for program_loader with a write
//            scoreboard fed by the stimulus and drained by a port-B monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [9:0]  addr_b;
    logic [15:0] data_b;
    logic        we_b;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_wr   = 0;

    typedef struct packed {
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t sb[$];

    program_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .addr_b    (addr_b),
        .data_b    (data_b),
        .we_b      (we_b),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Port-B monitor: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (we_b === 1'b1) begin
            wr_t e;
            n_wr++;
            if (sb.size() == 0) begin
                check("wr_unexpected", 32'(we_b), 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(addr_b), 32'(e.addr));
                check("wr_data", 32'(data_b), 32'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int tries = 0;
        bit sent  = 1'b0;
        while (!sent && tries < 200) begin
            @(negedge clk);
            rx_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            rx_data  = rx_valid ? b : 8'($urandom);
            sent     = rx_valid && rx_ready;
            tries++;
        end
        if (!sent) check("byte_timeout", 32'(sent), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [9:0] a, input logic [15:0] w, input bit rnd);
        wr_t e;
        e.addr = a;
        e.data = w;
        sb.push_back(e);
        send_byte(w[15:8], rnd);
        send_byte(w[7:0], rnd);
    endtask

    task automatic pulse_start(input bit with_byte);
        @(negedge clk);
        start    = 1'b1;
        rx_valid = with_byte;
        rx_data  = 8'hEE;
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic check_finish(input string tag);
        @(negedge clk);
        check({tag, "_we"}, 32'(we_b), 32'd1);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({tag, "_addr_b"}, 32'(addr_b), 32'd0);
        check({tag, "_data_b"}, 32'(data_b), 32'd0);
        check({tag, "_we_b"}, 32'(we_b), 32'd0);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0;

        // Power-on reset
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;

        // Three-word load; a byte offered with start in IDLE must not be consumed
        pulse_start(1'b1);
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_rx_ready", 32'(rx_ready), 32'd1);
        wr0 = n_wr;
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_word(10'd0, 16'h1234, 1'b0);
        send_word(10'd1, 16'hABCD, 1'b0);
        send_word(10'd2, 16'h00FF, 1'b0);
        check_finish("t2");
        check("t2_nwr", 32'(n_wr - wr0), 32'd3);

        // Backpressure with random rx_valid, restarting from DONE
        pulse_start(1'b0);
        check("t3_done_clr", 32'(done), 32'd0);
        check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        wr0 = n_wr;
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_word(10'd0, 16'hDEAD, 1'b1);
        send_word(10'd1, 16'hBEEF, 1'b1);
        check_finish("t3");
        check("t3_nwr", 32'(n_wr - wr0), 32'd2);

        // Zero length, oversize length, then a valid single-word load
        wr0 = n_wr;
        pulse_start(1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        check("t4a_error", 32'(error), 32'd1);
        check("t4a_busy", 32'(busy), 32'd0);
        check("t4a_rx_ready", 32'(rx_ready), 32'd0);
        check("t4a_cpu_reset", 32'(cpu_reset), 32'd1);
        pulse_start(1'b0);
        check("t4b_error_clr", 32'(error), 32'd0);
        check("t4b_busy", 32'(busy), 32'd1);
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        @(negedge clk);
        check("t4b_error", 32'(error), 32'd1);
        check("t4b_nwr", 32'(n_wr - wr0), 32'd0);
        pulse_start(1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_word(10'd0, 16'hC0DE, 1'b0);
        check_finish("t4c");
        check("t4c_error", 32'(error), 32'd0);
        check("t4_nwr", 32'(n_wr - wr0), 32'd1);

        // Full-depth load of 1024 words
        wr0 = n_wr;
        pulse_start(1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 1024; i++) begin
            send_word(10'(i), (16'(i) * 16'h9E37) ^ 16'h1357, 1'b0);
        end
        check_finish("t5");
        check("t5_nwr", 32'(n_wr - wr0), 32'd1024);
        check("t5_last_addr", 32'(addr_b), 32'h3FF);

        // Start while busy is ignored; asynchronous reset mid-load
        pulse_start(1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        sb.push_back(wr_t'{addr: 10'd0, data: 16'h1122});
        send_byte(8'h11, 1'b0);
        pulse_start(1'b0);
        check("t6_busy_hold", 32'(busy), 32'd1);
        check("t6_ready_hold", 32'(rx_ready), 32'd1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        wr0 = n_wr;
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("t6_rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_no_write", 32'(n_wr - wr0), 32'd0);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);
        pulse_start(1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_word(10'd0, 16'h55AA, 1'b0);
        check_finish("t6");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
